pc_redirect_select: RTL and testbench
=====================================

Name: pc_redirect_select

Overview:
- Parametrised successor to the PC-path 2:1 word select: an N-source prioritised next-PC selector fused with the PC register itself.
- Each cycle it chooses between sequential increment and any of N_SRC redirect sources (branch, jump, trap, etc.) and honours pipeline stall.
- A redirect that arrives during a stall is buffered and applied when the stall releases.
- Sits at the front of the IF stage and drives the instruction-memory address.

Parameters:
- WIDTH, 32, PC/address width in bits.
- N_SRC, 4, number of redirect sources; index 0 = highest priority.
- RESET_VECTOR, 32'h0000_0000, PC value after reset.
- INC, 4, sequential increment added to PC.
- ALIGN_BITS, 2, number of LSBs forced to 0 on every redirect address loaded (0 = no masking).
- SRC_W (localparam), max(1, clog2(N_SRC)), width of source index.

Ports:
- CLK  input  1  clock, rising-edge.
- RESET  input  1  asynchronous, active-high reset.
- STALL  input  1  1 = hold PC this cycle.
- REDIRECT_VALID  input  N_SRC  per-source redirect request, bit i = source i.
- REDIRECT_ADDR  input  N_SRC*WIDTH  flattened targets; source i at bits [i*WIDTH +: WIDTH].
- PC  output  WIDTH  current PC (registered).
- PC_PLUS_INC  output  WIDTH  PC + INC, combinational from PC, modulo 2^WIDTH.
- REDIRECT_TAKEN  output  1  registered; 1 for exactly the cycle after PC was loaded from a redirect.
- SRC_ID  output  SRC_W  registered index of the source that last loaded PC.
- PENDING  output  1  registered; 1 while a buffered redirect awaits stall release.

Behaviour:
- Reset (async, any time, including mid-stall with a pending entry):
  - PC = RESET_VECTOR, REDIRECT_TAKEN = 0, SRC_ID = 0, PENDING = 0.
  - Pending address and index cleared to 0.
  - First rising edge after RESET deasserts performs a normal update.
- New-request winner: lowest index i with REDIRECT_VALID[i] = 1; its address masked with ALIGN_BITS LSBs cleared.
- Candidate merge (new winner vs. pending entry):
  - Lower index wins.
  - Equal index: new request wins.
  - Only one present: that one.
- Rising edge with STALL = 0:
  - Candidate exists: PC <= candidate address, SRC_ID <= candidate index, REDIRECT_TAKEN <= 1, PENDING <= 0.
  - No candidate: PC <= PC + INC (wraps modulo 2^WIDTH), REDIRECT_TAKEN <= 0; SRC_ID holds; PENDING stays 0.
- Rising edge with STALL = 1:
  - PC and SRC_ID hold; REDIRECT_TAKEN <= 0.
  - Any new request: pending entry <= merge result, PENDING <= 1.
  - No new request: pending entry and PENDING unchanged.
- Latency: a redirect presented in cycle n with STALL = 0 appears on PC in cycle n+1. A buffered redirect appears on PC one cycle after the first edge with STALL = 0.
- Pending buffer depth is 1. A higher-priority or equal-index new request overwrites it; a lower-priority request is dropped.
- No X propagation: unused REDIRECT_ADDR slices whose valid bit is 0 never affect outputs.
- N_SRC = 1 must elaborate: SRC_W = 1, SRC_ID always 0.

Test Plan:
- Reset and increment: assert RESET mid-cycle, release, run 4 edges with no requests → PC 0x0, 0x4, 0x8, 0xC; PC_PLUS_INC = 0x10 at the end; REDIRECT_TAKEN stays 0.
- Priority and masking: VALID = 4'b0110, src1 = 0x0000_1003, src2 = 0x0000_2000, STALL = 0 → next cycle PC = 0x1000, SRC_ID = 1, REDIRECT_TAKEN = 1 for one cycle, then PC = 0x1004.
- Stall buffering: STALL = 1; src3 = 0x3000 for one cycle, then src1 = 0x1100 for one cycle, then src2 = 0x2200 → PENDING = 1, PC holds throughout; release STALL → PC = 0x1100, SRC_ID = 1, PENDING = 0.
- Simultaneous events: PENDING holds src2 = 0x2000, STALL drops in the same cycle src2 = 0x2400 is requested → PC = 0x2400. Repeat with a new src3 request instead → PC = 0x2000.
- Wrap-around: redirect to 0xFFFF_FFFC, then no requests → PC = 0xFFFF_FFFC, then 0x0000_0000.
- Reset mid-operation: PENDING = 1 during a stall, pulse RESET → PC = RESET_VECTOR and PENDING = 0 immediately (before the next edge); after release with STALL = 0, PC increments from RESET_VECTOR with no redirect applied.

Source files
------------

// File: rtl/pc_redirect_select_if.sv
// Purpose : Bundles the stall/redirect request side and the PC result side
//           of the next-PC selector into one interface.
// Signals : stall          - hold PC this cycle
//           redirect_valid - per-source redirect request, bit i = source i
//           redirect_addr  - flattened targets, source i at [i*WIDTH +: WIDTH]
//           pc             - current PC (registered)
//           pc_plus_inc    - pc + INC (combinational)
//           redirect_taken - PC was loaded from a redirect on the last edge
//           src_id         - index of the source that last loaded PC
//           pending        - a buffered redirect awaits stall release
// Modports: master drives requests (pipeline side), slave is the selector.
interface pc_redirect_select_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N_SRC = 4
);
  localparam int unsigned SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic                   stall;
  logic [N_SRC-1:0]       redirect_valid;
  logic [N_SRC*WIDTH-1:0] redirect_addr;
  logic [WIDTH-1:0]       pc;
  logic [WIDTH-1:0]       pc_plus_inc;
  logic                   redirect_taken;
  logic [SRC_W-1:0]       src_id;
  logic                   pending;

  modport master (
    output stall, redirect_valid, redirect_addr,
    input  pc, pc_plus_inc, redirect_taken, src_id, pending
  );

  modport slave (
    input  stall, redirect_valid, redirect_addr,
    output pc, pc_plus_inc, redirect_taken, src_id, pending
  );
endinterface

// File: rtl/pc_redirect_select.sv
// Purpose : PC register fused with an N-source prioritised next-PC selector.
//           Chooses between sequential increment and redirect sources
//           (index 0 = highest priority), honours stall, and buffers one
//           redirect that arrives while stalled.
// Ports   : clk_i - rising-edge clock
//           rst_i - asynchronous active-high reset
//           bus   - pc_redirect_select_if.slave (requests in, PC state out)
module pc_redirect_select #(
  parameter int unsigned     WIDTH        = 32,
  parameter int unsigned     N_SRC        = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int unsigned     INC          = 4,
  parameter int unsigned     ALIGN_BITS   = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  pc_redirect_select_if.slave   bus
);
  localparam int unsigned SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  // All-ones except the ALIGN_BITS LSBs; all-ones when ALIGN_BITS = 0.
  localparam logic [WIDTH-1:0] ALIGN_MASK =
    ~((WIDTH'(1) << ALIGN_BITS) - WIDTH'(1));

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             taken_q, taken_d;
  logic [SRC_W-1:0] src_q, src_d;
  logic             pend_q, pend_d;
  logic [WIDTH-1:0] pend_addr_q, pend_addr_d;
  logic [SRC_W-1:0] pend_idx_q, pend_idx_d;

  logic             new_vld;
  logic [SRC_W-1:0] new_idx;
  logic [WIDTH-1:0] new_addr;
  logic             cand_vld;
  logic [SRC_W-1:0] cand_idx;
  logic [WIDTH-1:0] cand_addr;

  // New-request winner: scan from lowest priority so the lowest index wins.
  // Addresses of non-valid sources are never selected.
  always_comb begin
    new_vld  = 1'b0;
    new_idx  = '0;
    new_addr = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (bus.redirect_valid[i]) begin
        new_vld  = 1'b1;
        new_idx  = SRC_W'(i);
        new_addr = bus.redirect_addr[i*WIDTH +: WIDTH] & ALIGN_MASK;
      end
    end
  end

  // Merge new winner with the buffered entry; ties go to the new request.
  always_comb begin
    cand_vld  = new_vld | pend_q;
    cand_idx  = pend_idx_q;
    cand_addr = pend_addr_q;
    if (new_vld && (!pend_q || (new_idx <= pend_idx_q))) begin
      cand_idx  = new_idx;
      cand_addr = new_addr;
    end
  end

  // Next-state for PC, status and the single-entry pending buffer.
  always_comb begin
    pc_d        = pc_q;
    taken_d     = 1'b0;
    src_d       = src_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    pend_idx_d  = pend_idx_q;
    if (!bus.stall) begin
      pend_d = 1'b0;
      if (cand_vld) begin
        pc_d    = cand_addr;
        src_d   = cand_idx;
        taken_d = 1'b1;
      end else begin
        pc_d = pc_q + WIDTH'(INC);
      end
    end else if (new_vld) begin
      pend_d      = 1'b1;
      pend_addr_d = cand_addr;
      pend_idx_d  = cand_idx;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q        <= RESET_VECTOR;
      taken_q     <= 1'b0;
      src_q       <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      pend_idx_q  <= '0;
    end else begin
      pc_q        <= pc_d;
      taken_q     <= taken_d;
      src_q       <= src_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      pend_idx_q  <= pend_idx_d;
    end
  end

  assign bus.pc             = pc_q;
  assign bus.pc_plus_inc    = pc_q + WIDTH'(INC);
  assign bus.redirect_taken = taken_q;
  assign bus.src_id         = src_q;
  assign bus.pending        = pend_q;
endmodule

// File: tb/tb_pc_redirect_select.sv
// Directed bench for pc_redirect_select (WIDTH=32, N_SRC=4, INC=4, ALIGN_BITS=2).
// Inputs change and outputs are sampled on the falling edge.
module tb_pc_redirect_select;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned N_SRC = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  pc_redirect_select_if #(.WIDTH(WIDTH), .N_SRC(N_SRC)) bus ();

  pc_redirect_select #(
    .WIDTH(WIDTH), .N_SRC(N_SRC), .RESET_VECTOR(32'h0000_0000),
    .INC(4), .ALIGN_BITS(2)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic req(input logic [3:0] vld, input int idx, input logic [31:0] addr);
    bus.redirect_valid = vld;
    bus.redirect_addr[idx*WIDTH +: WIDTH] = addr;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0;
    bus.stall = 1'b0;
    bus.redirect_valid = '0;
    bus.redirect_addr = '0;

    // Reset asserted mid-cycle, then sequential increment.
    #7 rst = 1'b1;
    #1;
    check("rst_pc", bus.pc, 32'h0);
    check("rst_taken", 32'(bus.redirect_taken), 32'h0);
    check("rst_src", 32'(bus.src_id), 32'h0);
    check("rst_pend", 32'(bus.pending), 32'h0);
    tick();
    rst = 1'b0;
    check("inc_pc0", bus.pc, 32'h0);
    tick(); check("inc_pc1", bus.pc, 32'h4);
    tick(); check("inc_pc2", bus.pc, 32'h8);
    tick(); check("inc_pc3", bus.pc, 32'hC);
    check("inc_plus", bus.pc_plus_inc, 32'h10);
    check("inc_taken", 32'(bus.redirect_taken), 32'h0);

    // Priority and alignment masking.
    bus.redirect_addr[1*WIDTH +: WIDTH] = 32'h0000_1003;
    bus.redirect_addr[2*WIDTH +: WIDTH] = 32'h0000_2000;
    bus.redirect_valid = 4'b0110;
    tick();
    bus.redirect_valid = '0;
    check("prio_pc", bus.pc, 32'h1000);
    check("prio_src", 32'(bus.src_id), 32'h1);
    check("prio_taken", 32'(bus.redirect_taken), 32'h1);
    tick();
    check("prio_next_pc", bus.pc, 32'h1004);
    check("prio_taken_drop", 32'(bus.redirect_taken), 32'h0);

    // Stall buffering: src3, then src1 overwrites, then src2 is dropped.
    bus.stall = 1'b1;
    req(4'b1000, 3, 32'h3000);
    tick();
    check("stall_pend0", 32'(bus.pending), 32'h1);
    check("stall_pc0", bus.pc, 32'h1004);
    req(4'b0010, 1, 32'h1100);
    tick();
    check("stall_pc1", bus.pc, 32'h1004);
    req(4'b0100, 2, 32'h2200);
    tick();
    check("stall_pc2", bus.pc, 32'h1004);
    check("stall_taken", 32'(bus.redirect_taken), 32'h0);
    bus.redirect_valid = '0;
    bus.stall = 1'b0;
    tick();
    check("release_pc", bus.pc, 32'h1100);
    check("release_src", 32'(bus.src_id), 32'h1);
    check("release_pend", 32'(bus.pending), 32'h0);
    check("release_taken", 32'(bus.redirect_taken), 32'h1);

    // Equal index at release: new request wins.
    bus.stall = 1'b1;
    req(4'b0100, 2, 32'h2000);
    tick();
    check("simul_pend", 32'(bus.pending), 32'h1);
    bus.stall = 1'b0;
    req(4'b0100, 2, 32'h2400);
    tick();
    bus.redirect_valid = '0;
    check("simul_eq_pc", bus.pc, 32'h2400);
    check("simul_eq_src", 32'(bus.src_id), 32'h2);

    // Lower-priority new request at release: pending entry wins.
    bus.stall = 1'b1;
    req(4'b0100, 2, 32'h2000);
    tick();
    bus.stall = 1'b0;
    req(4'b1000, 3, 32'h3000);
    tick();
    bus.redirect_valid = '0;
    check("simul_lo_pc", bus.pc, 32'h2000);
    check("simul_lo_src", 32'(bus.src_id), 32'h2);

    // Wrap-around.
    req(4'b0001, 0, 32'hFFFF_FFFC);
    tick();
    bus.redirect_valid = '0;
    check("wrap_pc", bus.pc, 32'hFFFF_FFFC);
    check("wrap_plus", bus.pc_plus_inc, 32'h0);
    check("wrap_src", 32'(bus.src_id), 32'h0);
    tick();
    check("wrap_pc_next", bus.pc, 32'h0);
    tick();
    check("wrap_pc_4", bus.pc, 32'h4);

    // Reset while a buffered redirect is pending.
    bus.stall = 1'b1;
    req(4'b0010, 1, 32'h1234);
    tick();
    bus.redirect_valid = '0;
    check("mid_pend", 32'(bus.pending), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_pc", bus.pc, 32'h0);
    check("mid_rst_pend", 32'(bus.pending), 32'h0);
    tick();
    rst = 1'b0;
    bus.stall = 1'b0;
    tick();
    check("post_rst_pc", bus.pc, 32'h4);
    check("post_rst_taken", 32'(bus.redirect_taken), 32'h0);
    tick();
    check("post_rst_pc2", bus.pc, 32'h8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
